// File: rtl/mux_arb.sv
// N-channel valid/ready arbiter (round-robin or fixed priority) that feeds
// a one-entry registered output stage.
module mux_arb #(
   parameter int BIT_WIDTH = 32,
   parameter int DEPTH     = 4,
   parameter int SEL_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int MODE      = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
   input  logic [DEPTH-1:0]           inValid,
   output logic [DEPTH-1:0]           inReady,
   output logic [BIT_WIDTH-1:0]       dataOut,
   output logic [SEL_WIDTH-1:0]       outSel,
   output logic                       outValid,
   input  logic                       outReady
);

   localparam logic [SEL_WIDTH-1:0] LAST_RST = SEL_WIDTH'(DEPTH - 1);

   logic [DEPTH-1:0][BIT_WIDTH-1:0] chan_w;
   logic [SEL_WIDTH-1:0]            last_q, last_d, ptr;
   logic [BIT_WIDTH-1:0]            data_q, data_d, gnt_word;
   logic [SEL_WIDTH-1:0]            sel_q, sel_d, gnt_idx, hi_idx, lo_idx;
   logic                            vld_q, vld_d;
   logic                            hit_hi, hit_lo, any_req, load;
   logic [DEPTH-1:0]                grant;

   for (genvar g = 0; g < DEPTH; g++) begin : g_chan
      assign chan_w[g] = dataIn[BIT_WIDTH*g +: BIT_WIDTH];
   end

   // Fixed priority is round-robin with the pointer pinned at DEPTH-1,
   // so the search always starts at channel 0.
   assign ptr = (MODE == 1) ? LAST_RST : last_q;

   // Lowest valid index above the pointer wins; otherwise wrap to the
   // lowest valid index at or below it.
   always_comb begin
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (inValid[i]) begin
            if (SEL_WIDTH'(i) > ptr) begin
               hit_hi = 1'b1;
               hi_idx = SEL_WIDTH'(i);
            end else begin
               hit_lo = 1'b1;
               lo_idx = SEL_WIDTH'(i);
            end
         end
      end
      any_req = hit_hi | hit_lo;
      gnt_idx = hit_hi ? hi_idx : lo_idx;
   end

   always_comb begin
      grant    = '0;
      gnt_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant[i] = any_req && (SEL_WIDTH'(i) == gnt_idx);
         gnt_word = gnt_word | (chan_w[i] & {BIT_WIDTH{grant[i]}});
      end
   end

   assign load    = !vld_q || outReady;
   assign inReady = rst ? '0 : (grant & {DEPTH{load}});

   always_comb begin
      data_d = data_q;
      sel_d  = sel_q;
      vld_d  = vld_q;
      last_d = last_q;
      if (load) begin
         if (any_req) begin
            data_d = gnt_word;
            sel_d  = gnt_idx;
            vld_d  = 1'b1;
            if (MODE == 0) last_d = gnt_idx;
         end else begin
            vld_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         sel_q  <= '0;
         vld_q  <= 1'b0;
         last_q <= LAST_RST;
      end else begin
         data_q <= data_d;
         sel_q  <= sel_d;
         vld_q  <= vld_d;
         last_q <= last_d;
      end
   end

   assign dataOut  = data_q;
   assign outSel   = sel_q;
   assign outValid = vld_q;

endmodule

// File: doc/mux_arb.md
Name: mux_arb

Overview:
- Parametrised successor to the combinational mux wrapper: DEPTH input channels, each with a valid/ready handshake.
- Arbitrates among active channels (round-robin or fixed priority) and registers the selected word into a one-entry output stage with its own valid/ready handshake.
- Used wherever several pipeline producers share one consumer, e.g. writeback/forwarding sources or memory request merging.

Parameters:
- BIT_WIDTH, 32, bits per channel word.
- DEPTH, 4, number of input channels; legal range 1..16.
- SEL_WIDTH, log2(DEPTH) with minimum 1, width of the granted-channel index.
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- dataIn  input  BIT_WIDTH*DEPTH  vectorised channel words; channel i at [BIT_WIDTH*(i+1)-1 : BIT_WIDTH*i].
- inValid  input  DEPTH  channel i presents a word.
- inReady  output  DEPTH  channel i word is accepted this cycle.
- dataOut  output  BIT_WIDTH  registered selected word.
- outSel  output  SEL_WIDTH  index of the channel that supplied dataOut.
- outValid  output  1  dataOut/outSel hold a word.
- outReady  input  1  consumer accepts the word this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: outValid=0, dataOut=0, outSel=0. Round-robin pointer last=DEPTH-1, so channel 0 has highest priority first.
- Load condition: load = !outValid | outReady. The output stage may accept a new word when empty or when being drained in the same cycle.
- Grant:
  - Combinational one-hot grant over inValid, evaluated every cycle.
  - inReady[i] = load & grant[i]. At most one inReady bit is high.
  - inReady may depend combinationally on outReady. This is the only combinational in-to-out path.
- Transfer: when load & |inValid:
  - dataOut <= granted word; outSel <= granted index; outValid <= 1.
  - Latency is 1 cycle from input acceptance to outValid.
- Drain without refill: load & !(|inValid) & outReady -> outValid <= 0. dataOut and outSel hold their stale values.
- Stall: outValid & !outReady -> dataOut, outSel, outValid hold. All inReady=0. The round-robin pointer holds.
- Round-robin (MODE=0):
  - Search order is last+1, last+2, ... wrapping mod DEPTH. The first valid channel wins.
  - last <= granted index, only on a cycle with an actual transfer.
  - Wrap-around: with last=DEPTH-1, the search starts at channel 0.
- Fixed priority (MODE=1): the lowest-index valid channel wins. The pointer is unused and held at reset value.
- Input rules:
  - A channel may deassert inValid or change its data while not granted; no input is ever latched unless inReady is high.
  - Once inValid is asserted, a channel keeps its word until inReady; the arbiter does not require this to be correct.
- Simultaneous drain and refill: outValid & outReady & |inValid -> new word loaded the same edge; outValid stays 1, giving full throughput.
- DEPTH=1: grant = inValid[0]; outSel is always 0; behaves as a one-stage pipeline register.
- Reset mid-operation: any held word is discarded, outputs take reset values, and the pointer returns to DEPTH-1 on the same edge.
- While rst=1: inReady=0.

Test Plan:
- Reset check, DEPTH=4, MODE=0: hold rst 2 cycles with inValid=4'b1111 -> inReady=0, outValid=0, dataOut=0, outSel=0; first cycle after reset grants channel 0.
- Round-robin fairness: inValid=4'b1111 held, outReady=1, dataIn channel i = 32'hA0+i -> dataOut sequence A0,A1,A2,A3,A0 on consecutive cycles, outSel 0,1,2,3,0, outValid constant 1.
- Backpressure: outValid=1 with dataOut=A2, outReady=0 for 3 cycles -> dataOut/outSel hold, inReady=0, pointer unchanged; releasing outReady next grants channel 3.
- Sparse requests and wrap: last=2, inValid=4'b0011 -> channel 0 granted (wraps past 3), then channel 1; inValid=0 with outReady=1 -> outValid drops to 0 next edge.
- Fixed priority, MODE=1: inValid=4'b1010 held, outReady=1 -> channel 1 granted every cycle, channel 3 starved, inReady=4'b0010.
- Reset mid-stall: outValid=1, outReady=0, dataOut=A1, assert rst one cycle -> outValid=0, dataOut=0, next grant with inValid=4'b1111 is channel 0.
